// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall hold vectors,
// controller state encoding and common bus constants.
package pipe_ctrl_pkg;

    localparam int RegBusW = 32;
    typedef logic [RegBusW-1:0] reg_bus_t;

    localparam reg_bus_t ZeroWord  = '0;
    localparam logic     RstEnable = 1'b1;
    localparam logic     Stop      = 1'b1;
    localparam logic     NoStop    = 1'b0;

    // Hold vector bit order: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] wb
    typedef logic [5:0] stall_vec_t;

    localparam stall_vec_t StallNone = 6'b000000;
    localparam stall_vec_t StallId   = 6'b000111;
    localparam stall_vec_t StallEx   = 6'b001111;
    localparam stall_vec_t StallMem  = 6'b011111;

    typedef enum logic {
        CtrlRun   = 1'b0,
        CtrlFlush = 1'b1
    } ctrl_state_e;

    // The deepest requesting stage wins: a MEM wait must also freeze everything upstream.
    function automatic stall_vec_t stall_encode(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        stall_vec_t v;
        if (req_mem == Stop) begin
            v = StallMem;
        end else if (req_ex == Stop) begin
            v = StallEx;
        end else if (req_id == Stop) begin
            v = StallId;
        end else begin
            v = StallNone;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdt.sv
// MEM-wait watchdog: counts consecutive stalled-on-MEM cycles and emits a
// single-cycle expiry when the count would reach TIMEOUT.
module pipe_wdt
    import pipe_ctrl_pkg::*;
#(
    parameter int WDT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stallreq_mem_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [WDT_W-1:0] LastCnt = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] cnt_d;

    // Next count and expiry; expiry restarts the count so a stuck bus re-arms cleanly.
    always_comb begin
        expire_o = 1'b0;
        cnt_d    = cnt_q;
        if (clr_i || !stallreq_mem_i) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            expire_o = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the hold vector,
// sequences exception / timeout flushes with a PC redirect, and keeps a
// saturating count of PC-stalled cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CtrlRun   | normal operation, stall requests honoured, watchdog armed
// CtrlFlush | flush asserted, stalls ignored, counter sets window length
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int       FLUSH_CYCLES = 1,
    parameter int       WDT_W        = 8,
    parameter int       TIMEOUT      = 255,
    parameter reg_bus_t TIMEOUT_VEC  = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] exc_vec,
    input  logic        perf_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout,
    output logic [31:0] stall_cycles
);

    localparam int FcW = 4;
    localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYCLES);

    ctrl_state_e      state_q, state_d;
    logic [FcW-1:0]   fcnt_q, fcnt_d;
    reg_bus_t         new_pc_q, new_pc_d;
    logic             timeout_q, timeout_d;
    reg_bus_t         stall_cycles_q;
    logic             wdt_clr;
    logic             wdt_expire;

    // Any flush activity restarts the MEM-wait measurement.
    assign wdt_clr = (state_q == CtrlFlush) || flush_req;

    pipe_wdt #(
        .WDT_W   (WDT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk            (clk),
        .rst            (rst),
        .stallreq_mem_i (stallreq_mem),
        .clr_i          (wdt_clr),
        .expire_o       (wdt_expire)
    );

    // State, flush counter, redirect PC and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= CtrlRun;
            fcnt_q    <= '0;
            new_pc_q  <= ZeroWord;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            new_pc_q  <= new_pc_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; an exception request always beats a coincident watchdog expiry.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        new_pc_d  = new_pc_q;
        timeout_d = 1'b0;
        unique case (state_q)
            CtrlRun: begin
                if (flush_req) begin
                    state_d  = CtrlFlush;
                    fcnt_d   = FlushLoad;
                    new_pc_d = exc_vec;
                end else if (wdt_expire) begin
                    state_d   = CtrlFlush;
                    fcnt_d    = FlushLoad;
                    new_pc_d  = TIMEOUT_VEC;
                    timeout_d = 1'b1;
                end
            end
            CtrlFlush: begin
                if (flush_req) begin
                    fcnt_d   = FlushLoad;
                    new_pc_d = exc_vec;
                end else if (fcnt_q == FcW'(1)) begin
                    state_d = CtrlRun;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CtrlRun;
                fcnt_d  = '0;
            end
        endcase
    end

    // Outputs: stall is combinational so stage registers hold in the requesting cycle.
    always_comb begin
        flush   = (state_q == CtrlFlush);
        new_pc  = new_pc_q;
        timeout = timeout_q;
        stall   = StallNone;
        if ((rst != RstEnable) && (state_q == CtrlRun)) begin
            stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
        end
    end

    // Saturating count of PC-stalled cycles; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cycles_q <= ZeroWord;
        end else if (perf_clr) begin
            stall_cycles_q <= ZeroWord;
        end else if (stall[0] && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
